// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch-in-MEM,
// multi-cycle data memory handshake, post-reset purge and stall counter.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic mem_stall;
  logic br_taken;
  logic load_use;
  logic init_done;
  logic wait_to;

  assign mem_stall = mem_req & ~mem_ready;
  assign br_taken  = exmem_branch & exmem_zero;
  assign load_use  = idex_mem_read & (idex_rt != 5'd0)
                   & ((idex_rt == id_rs)
                   | (id_uses_rt & (idex_rt == id_rt)));
  assign init_done = (init_cnt_q == IW'(INIT_CYCLES - 1));
  assign wait_to   = (wait_cnt_q == WW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_INIT;
      init_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      mem_error_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_error_q    <= mem_error_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_error_d    = mem_error_q;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (mem_stall) begin
          wait_cnt_d = WW'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = S_RUN;
        end else if (wait_to) begin
          wait_cnt_d  = '0;
          mem_error_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
    // purge cycles are not stalls; saturate instead of wrapping
    if (state_q != S_INIT && !pc_write && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    unique case (state_q)
      S_INIT: begin
        pc_write    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
      end
      S_RUN, S_WAIT: begin
        if ((state_q == S_RUN && mem_stall)
            || (state_q == S_WAIT && !mem_ready && !wait_to)) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
        end else if (state_q == S_WAIT && !mem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          memwb_flush = 1'b1;
        end else if (br_taken) begin
          pc_src      = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        id_uses_rt, idex_mem_read;
  logic        exmem_branch, exmem_zero;
  logic        mem_req, mem_ready;
  logic        pc_write, pc_src;
  logic        ifid_write, ifid_flush;
  logic        idex_write, idex_flush;
  logic        exmem_write, exmem_flush;
  logic        memwb_flush, mem_error;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  // {pc_write,pc_src,ifid_w,ifid_f,idex_w,idex_f,exmem_w,exmem_f,memwb_f}
  localparam logic [8:0] C_INIT = 9'b0_0_1_1_1_1_1_1_1;
  localparam logic [8:0] C_DEF  = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] C_MST  = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] C_BR   = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] C_TO   = 9'b0_0_0_0_0_0_1_1_1;

  logic [8:0] ctl;
  assign ctl = {pc_write, pc_src, ifid_write, ifid_flush,
                idex_write, idex_flush, exmem_write,
                exmem_flush, memwb_flush};

  pipeline_hazard_ctrl #(
    .INIT_CYCLES(2),
    .MAX_WAIT(16),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read),
    .idex_rt(idex_rt),
    .exmem_branch(exmem_branch),
    .exmem_zero(exmem_zero),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .ifid_write(ifid_write),
    .ifid_flush(ifid_flush),
    .idex_write(idex_write),
    .idex_flush(idex_flush),
    .exmem_write(exmem_write),
    .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush),
    .mem_error(mem_error),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    id_uses_rt    = 1'b0;
    idex_mem_read = 1'b0;
    idex_rt       = 5'd0;
    exmem_branch  = 1'b0;
    exmem_zero    = 1'b0;
    mem_req       = 1'b0;
    mem_ready     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset_n = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_INIT));
    chk("rst_cnt", 32'(stall_cycles), 0);
    chk("rst_err", 32'(mem_error), 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    chk("init1", 32'(ctl), 32'(C_INIT));
    cyc();
    #1;
    chk("init2", 32'(ctl), 32'(C_INIT));
    cyc();
    #1;
    chk("run_def", 32'(ctl), 32'(C_DEF));
    chk("init_cnt0", 32'(stall_cycles), 0);

    idex_mem_read = 1'b1;
    idex_rt = 5'd5;
    id_rs   = 5'd5;
    #1;
    chk("lu_rs", 32'(ctl), 32'(C_LU));
    cyc();
    idle();
    #1;
    chk("lu_clr", 32'(ctl), 32'(C_DEF));
    chk("lu_cnt", 32'(stall_cycles), 1);

    idex_mem_read = 1'b1;
    #1;
    chk("lu_r0", 32'(ctl), 32'(C_DEF));
    idex_rt = 5'd7;
    id_rs = 5'd3;
    id_rt = 5'd7;
    id_uses_rt = 1'b1;
    #1;
    chk("lu_rt", 32'(ctl), 32'(C_LU));
    id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 32'(ctl), 32'(C_DEF));
    id_uses_rt = 1'b1;
    exmem_branch = 1'b1;
    exmem_zero = 1'b1;
    #1;
    chk("br_over_lu", 32'(ctl), 32'(C_BR));
    cyc();
    idle();
    mem_ready = 1'b1;
    #1;
    chk("rdy_noreq", 32'(ctl), 32'(C_DEF));
    chk("br_cnt", 32'(stall_cycles), 1);

    mem_ready = 1'b0;
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw3_stall", 32'(ctl), 32'(C_MST));
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("mw3_rel", 32'(ctl), 32'(C_DEF));
    cyc();
    idle();
    #1;
    chk("mw3_cnt", 32'(stall_cycles), 4);

    mem_req = 1'b1;
    exmem_branch = 1'b1;
    exmem_zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("mwbr_hold", 32'(ctl), 32'(C_MST));
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("mwbr_rel", 32'(ctl), 32'(C_BR));
    cyc();
    idle();
    #1;
    chk("mwbr_after", 32'(ctl), 32'(C_DEF));
    chk("mwbr_cnt", 32'(stall_cycles), 6);

    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("to_stall", 32'(ctl), 32'(C_MST));
      cyc();
    end
    #1;
    chk("to_abort", 32'(ctl), 32'(C_TO));
    chk("to_err0", 32'(mem_error), 0);
    cyc();
    #1;
    chk("to_err1", 32'(mem_error), 1);
    chk("to_cnt", 32'(stall_cycles), 22);
    chk("to_restall", 32'(ctl), 32'(C_MST));
    cyc();
    #1;
    chk("to_wait", 32'(ctl), 32'(C_MST));
    chk("to_sticky", 32'(mem_error), 1);

    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ctl", 32'(ctl), 32'(C_INIT));
    chk("arst_err", 32'(mem_error), 0);
    chk("arst_cnt", 32'(stall_cycles), 0);
    cyc();
    reset_n = 1'b1;
    #1;
    chk("re_init1", 32'(ctl), 32'(C_INIT));
    cyc();
    #1;
    chk("re_init2", 32'(ctl), 32'(C_INIT));
    cyc();
    #1;
    chk("re_run", 32'(ctl), 32'(C_MST));
    idle();
    #1;
    chk("re_def", 32'(ctl), 32'(C_DEF));
    chk("re_cnt", 32'(stall_cycles), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
